pwm_ramp_ctrl: RTL and testbench



---
 rtl/pwm_ramp_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// Avalon-MM ramp sequencer for a pwm core: walks pulse_width toward a
// target in bounded steps, one step every INTERVAL pwm period wraps.
module pwm_ramp_ctrl #(
    parameter int N          = 32,
    parameter int RST_PERIOD = 1000
) (
    input  logic         csi_clk,
    input  logic         reset_n,
    input  logic [2:0]   avs_s0_address,
    input  logic         avs_s0_chipselect,
    input  logic         avs_s0_read,
    output logic [31:0]  avs_s0_readdata,
    input  logic         avs_s0_write,
    input  logic [31:0]  avs_s0_writedata,
    input  logic [3:0]   avs_s0_byteenable,
    output logic         ins_irq,
    output logic [N-1:0] coe_period,
    output logic [N-1:0] coe_pulse_width,
    output logic         coe_pwm_enable,
    input  logic         coe_cycle_end
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_STEP,
        S_DONE
    } state_t;

    state_t state;

    logic         en;
    logic         irq_en;
    logic         done;
    logic [N-1:0] period;
    logic [N-1:0] target;
    logic [N-1:0] step;
    logic [N-1:0] interval;
    logic [N-1:0] current;
    logic [N-1:0] cnt;

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] d,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
        end
        return r;
    endfunction

    logic wr;
    logic rd;
    logic wr_ctrl;
    logic wr_status;
    logic wr_period;
    logic wr_target;
    logic wr_step;
    logic wr_interval;
    logic wr_current;
    logic start;
    logic en_next;
    logic busy;

    assign wr          = avs_s0_chipselect & avs_s0_write;
    assign rd          = avs_s0_chipselect & avs_s0_read;
    assign wr_ctrl     = wr && (avs_s0_address == 3'd0);
    assign wr_status   = wr && (avs_s0_address == 3'd1);
    assign wr_period   = wr && (avs_s0_address == 3'd2);
    assign wr_target   = wr && (avs_s0_address == 3'd3);
    assign wr_step     = wr && (avs_s0_address == 3'd4);
    assign wr_interval = wr && (avs_s0_address == 3'd5);
    assign wr_current  = wr && (avs_s0_address == 3'd6);

    assign start   = wr_ctrl & avs_s0_byteenable[0] & avs_s0_writedata[2];
    assign en_next = (wr_ctrl & avs_s0_byteenable[0]) ? avs_s0_writedata[0] : en;
    assign busy    = (state == S_WAIT) || (state == S_STEP);

    logic [31:0] period_m;
    logic [31:0] target_m;
    logic [31:0] step_m;
    logic [31:0] interval_m;
    logic [31:0] current_m;

    assign period_m   = merge(32'(period), avs_s0_writedata, avs_s0_byteenable);
    assign target_m   = merge(32'(target), avs_s0_writedata, avs_s0_byteenable);
    assign step_m     = merge(32'(step), avs_s0_writedata, avs_s0_byteenable);
    assign interval_m = merge(32'(interval), avs_s0_writedata, avs_s0_byteenable);
    assign current_m  = merge(32'(current), avs_s0_writedata, avs_s0_byteenable);

    // Next pulse width, computed one bit wider so neither direction wraps.
    logic [N:0]   s_eff;
    logic [N:0]   cur_x;
    logic [N:0]   tgt_x;
    logic [N:0]   sum;
    logic [N:0]   lim;
    logic [N:0]   diff;
    logic [N-1:0] nxt;
    logic [N-1:0] intv_ld;

    always_comb begin
        s_eff = (step == '0) ? (N+1)'(1) : {1'b0, step};
        cur_x = {1'b0, current};
        tgt_x = {1'b0, target};
        sum   = cur_x + s_eff;
        lim   = tgt_x + s_eff;
        diff  = cur_x - s_eff;
        nxt   = current;
        if (cur_x < tgt_x) begin
            nxt = (sum > tgt_x) ? target : sum[N-1:0];
        end else if (cur_x > tgt_x) begin
            nxt = (cur_x >= lim) ? diff[N-1:0] : target;
        end
        intv_ld = (interval == '0) ? N'(1) : interval;
    end

    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        unique case (avs_s0_address)
            3'd0: rd_mux = {30'd0, irq_en, en};
            3'd1: rd_mux = {30'd0, done, busy};
            3'd2: rd_mux = 32'(period);
            3'd3: rd_mux = 32'(target);
            3'd4: rd_mux = 32'(step);
            3'd5: rd_mux = 32'(interval);
            3'd6: rd_mux = 32'(current);
            3'd7: rd_mux = '0;
        endcase
    end

    always_ff @(posedge csi_clk) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            en              <= 1'b0;
            irq_en          <= 1'b0;
            done            <= 1'b0;
            period          <= N'(RST_PERIOD);
            target          <= '0;
            step            <= N'(1);
            interval        <= N'(1);
            current         <= '0;
            cnt             <= '0;
            avs_s0_readdata <= '0;
        end else begin
            if (rd) avs_s0_readdata <= rd_mux;

            if (wr_ctrl && avs_s0_byteenable[0]) begin
                en     <= avs_s0_writedata[0];
                irq_en <= avs_s0_writedata[1];
            end
            if (wr_period)   period   <= period_m[N-1:0];
            if (wr_target)   target   <= target_m[N-1:0];
            if (wr_step)     step     <= step_m[N-1:0];
            if (wr_interval) interval <= interval_m[N-1:0];
            if (wr_current && !busy) current <= current_m[N-1:0];

            // Completion set beats a same-cycle clear.
            if (state == S_DONE) begin
                done <= 1'b1;
            end else if (wr_status && avs_s0_byteenable[0] && avs_s0_writedata[1]) begin
                done <= 1'b0;
            end

            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start && en_next) begin
                        cnt   <= intv_ld;
                        state <= S_WAIT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (!en_next) begin
                        state <= S_IDLE;
                    end else if (start) begin
                        cnt <= intv_ld;
                    end else if (coe_cycle_end) begin
                        if (cnt == N'(1)) state <= S_STEP;
                        else cnt <= cnt - N'(1);
                    end
                end
                S_STEP: begin
                    if (!en_next) begin
                        state <= S_IDLE;
                    end else if (start) begin
                        cnt   <= intv_ld;
                        state <= S_WAIT;
                    end else begin
                        current <= nxt;
                        if (nxt == target) begin
                            state <= S_DONE;
                        end else begin
                            cnt   <= intv_ld;
                            state <= S_WAIT;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign coe_period      = period;
    assign coe_pulse_width = current;
    assign coe_pwm_enable  = en;
    assign ins_irq         = done & irq_en;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Randomized bench for pwm_ramp_ctrl; expected widths come from a plain
// arithmetic ramp model evaluated inside the bench.
module tb_pwm_ramp_ctrl;

    logic        csi_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic        irq;
    logic [31:0] period;
    logic [31:0] pulse_width;
    logic        pwm_enable;
    logic        cycle_end = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 csi_clk = ~csi_clk;

    pwm_ramp_ctrl dut (
        .csi_clk           (csi_clk),
        .reset_n           (reset_n),
        .avs_s0_address    (address),
        .avs_s0_chipselect (chipselect),
        .avs_s0_read       (read),
        .avs_s0_readdata   (readdata),
        .avs_s0_write      (write),
        .avs_s0_writedata  (writedata),
        .avs_s0_byteenable (byteenable),
        .ins_irq           (irq),
        .coe_period        (period),
        .coe_pulse_width   (pulse_width),
        .coe_pwm_enable    (pwm_enable),
        .coe_cycle_end     (cycle_end)
    );

    task automatic idle(input int n);
        repeat (n) @(negedge csi_clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d,
                             input logic [3:0] be);
        @(negedge csi_clk);
        address = a; chipselect = 1'b1; write = 1'b1;
        writedata = d; byteenable = be;
        @(negedge csi_clk);
        chipselect = 1'b0; write = 1'b0; byteenable = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge csi_clk);
        address = a; chipselect = 1'b1; read = 1'b1;
        @(negedge csi_clk);
        d = readdata;
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic pulse_end();
        @(negedge csi_clk);
        cycle_end = 1'b1;
        @(negedge csi_clk);
        cycle_end = 1'b0;
    endtask

    // One ramp step: move toward target by max(step,1), never overshoot.
    function automatic logic [31:0] model_next(input logic [31:0] cur,
                                               input logic [31:0] tgt,
                                               input logic [31:0] stp);
        longint c, t, s;
        c = longint'(cur); t = longint'(tgt);
        s = (stp == 0) ? 1 : longint'(stp);
        if (c < t) return (c + s > t) ? tgt : 32'(c + s);
        if (c > t) return (c < t + s) ? tgt : 32'(c - s);
        return cur;
    endfunction

    task automatic do_reset();
        @(negedge csi_clk);
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
    endtask

    task automatic run_ramp(input logic [31:0] cur0, input logic [31:0] tgt,
                            input logic [31:0] stp, input logic [31:0] intv,
                            input int gap);
        logic [31:0] q[$];
        logic [31:0] cur;
        logic [31:0] prev;
        logic [31:0] rd;
        int n;
        bus_write(3'd6, cur0, 4'hF);
        bus_write(3'd3, tgt, 4'hF);
        bus_write(3'd4, stp, 4'hF);
        bus_write(3'd5, intv, 4'hF);
        bus_write(3'd1, 32'h2, 4'hF);
        bus_write(3'd0, 32'h7, 4'hF);
        cur = cur0;
        do begin
            cur = model_next(cur, tgt, stp);
            q.push_back(cur);
        end while (cur != tgt);
        n = (intv == 0) ? 1 : int'(intv);
        prev = cur0;
        foreach (q[i]) begin
            for (int k = 0; k < n; k++) begin
                idle((gap < 0) ? int'($urandom_range(0, 3)) : gap);
                pulse_end();
                if (k < n - 1) begin
                    n_checks++;
                    if (pulse_width !== prev) begin
                        n_fail++;
                        $display("FAIL hold_width got %0h want %0h", pulse_width, prev);
                    end
                end
            end
            idle(1);
            n_checks++;
            if (pulse_width !== q[i]) begin
                n_fail++;
                $display("FAIL step_width[%0d] got %0h want %0h", i, pulse_width, q[i]);
            end
            prev = q[i];
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_early got %b want 0", irq);
        end
        idle(1);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_done got %b want 1", irq);
        end
        bus_read(3'd1, rd);
        n_checks++;
        if (rd !== 32'h2) begin
            n_fail++;
            $display("FAIL status_done got %0h want 2", rd);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] exp_v[3];
        logic [2:0]  adr[3];
        do_reset();
        n_checks++;
        if (readdata !== 32'd0 || irq !== 1'b0 || pwm_enable !== 1'b0 ||
            period !== 32'd1000 || pulse_width !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got rd=%0h irq=%b en=%b per=%0d pw=%0d want 0 0 0 1000 0",
                     readdata, irq, pwm_enable, period, pulse_width);
        end
        adr = '{3'd2, 3'd4, 3'd5};
        exp_v = '{32'd1000, 32'd1, 32'd1};
        for (int i = 0; i < 3; i++) begin
            bus_read(adr[i], rd);
            n_checks++;
            if (rd !== exp_v[i]) begin
                n_fail++;
                $display("FAIL reset_read[%0d] got %0h want %0h", adr[i], rd, exp_v[i]);
            end
        end
        bus_read(3'd7, rd);
        n_checks++;
        if (rd !== 32'd0) begin
            n_fail++;
            $display("FAIL read_addr7 got %0h want 0", rd);
        end
    endtask

    task automatic test_ramp_up();
        run_ramp(32'd0, 32'd10, 32'd3, 32'd2, 19);
        n_checks++;
        if (pulse_width !== 32'd10) begin
            n_fail++;
            $display("FAIL ramp_up_final got %0d want 10", pulse_width);
        end
    endtask

    task automatic test_ramp_down_clear();
        logic [31:0] rd;
        run_ramp(32'd10, 32'd0, 32'd4, 32'd0, -1);
        bus_write(3'd1, 32'h2, 4'hF);
        bus_read(3'd1, rd);
        n_checks++;
        if (rd !== 32'd0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL done_clear got status=%0h irq=%b want 0 0", rd, irq);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        bus_write(3'd6, 32'd0, 4'hF);
        bus_write(3'd3, 32'd10, 4'hF);
        bus_write(3'd4, 32'd3, 4'hF);
        bus_write(3'd5, 32'd1, 4'hF);
        bus_write(3'd0, 32'h7, 4'hF);
        repeat (2) begin
            pulse_end();
            idle(1);
        end
        n_checks++;
        if (pulse_width !== 32'd6) begin
            n_fail++;
            $display("FAIL abort_pre got %0d want 6", pulse_width);
        end
        bus_write(3'd0, 32'h0, 4'hF);
        bus_read(3'd1, rd);
        n_checks++;
        if (rd !== 32'd0 || pwm_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_status got %0h en=%b want 0 0", rd, pwm_enable);
        end
        repeat (3) pulse_end();
        idle(2);
        bus_read(3'd1, rd);
        n_checks++;
        if (pulse_width !== 32'd6 || rd !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_hold got pw=%0d status=%0h want 6 0", pulse_width, rd);
        end
    endtask

    task automatic test_wide_no_wrap();
        bus_write(3'd6, 32'hFFFF_FFF0, 4'hF);
        bus_write(3'd3, 32'hFFFF_FFFF, 4'hF);
        bus_write(3'd4, 32'h20, 4'hF);
        bus_write(3'd5, 32'd1, 4'hF);
        bus_write(3'd1, 32'h2, 4'hF);
        bus_write(3'd0, 32'h7, 4'hF);
        bus_write(3'd6, 32'd5, 4'hF);
        n_checks++;
        if (pulse_width !== 32'hFFFF_FFF0) begin
            n_fail++;
            $display("FAIL busy_cur_write got %0h want fffffff0", pulse_width);
        end
        pulse_end();
        idle(1);
        n_checks++;
        if (pulse_width !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL no_wrap got %0h want ffffffff", pulse_width);
        end
        idle(1);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL wide_irq got %b want 1", irq);
        end
    endtask

    task automatic test_byteenable_start_off();
        logic [31:0] rd;
        do_reset();
        bus_write(3'd2, 32'h1234_5678, 4'h1);
        n_checks++;
        if (period !== 32'h0000_0378) begin
            n_fail++;
            $display("FAIL be_period got %0h want 378", period);
        end
        bus_write(3'd0, 32'h4, 4'hF);
        bus_read(3'd1, rd);
        n_checks++;
        if (rd !== 32'd0 || pwm_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL start_en0 got status=%0h en=%b want 0 0", rd, pwm_enable);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_ramp($urandom_range(0, 200), $urandom_range(0, 200),
                     $urandom_range(0, 40), $urandom_range(0, 3), -1);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down_clear();
        test_abort();
        test_wide_no_wrap();
        test_byteenable_start_off();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
